// File: rtl/calc_pkg.sv
// Shared digit codes and FSM state type for the calculator display path.
// The 7-segment decoders use the same constants for their case labels.
package calc_pkg;

    typedef logic [3:0] digit_t;

    localparam digit_t DIG_H     = 4'hA;
    localparam digit_t DIG_MINUS = 4'hB;
    localparam digit_t DIG_BLANK = 4'hD;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

endpackage

// File: rtl/calc_dabble_step.sv
// One shift-add-3 iteration: every BCD nibble >= 5 gets +3, then the register
// shifts left by one with carry_in entering the units digit.
module calc_dabble_step
    import calc_pkg::*;
#(
    parameter int NDIG = 3
) (
    input  logic [4*NDIG-1:0] bcd_in,
    input  logic              carry_in,
    output logic [4*NDIG-1:0] bcd_out,
    output logic              carry_out
);

    logic [4*NDIG-1:0] adj;

    always_comb begin
        adj = bcd_in;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_in[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
            end
        end
        bcd_out   = {adj[4*NDIG-2:0], carry_in};
        carry_out = adj[4*NDIG-1];
    end

endmodule

// File: rtl/calc_bin_to_digits.sv
// Converts an ALU result word to sign + NDIG display digit codes with a
// start/done handshake, leading-zero blanking and overflow indication.
module calc_bin_to_digits
    import calc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NDIG  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    input  logic                  is_signed,
    input  logic                  ovf,
    output logic                  busy,
    output logic                  done,
    output logic [4*(NDIG+1)-1:0] digits
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t               state;
    logic [4*NDIG-1:0]    bcd;
    logic [4*NDIG-1:0]    bcd_next;
    logic                 bcd_carry;
    logic [WIDTH-1:0]     mag;
    logic [CW-1:0]        cnt;
    logic                 neg_r;
    logic                 ovf_r;
    logic                 neg_in;
    logic [4*(NDIG+1)-1:0] composed;

    assign neg_in = is_signed & value[WIDTH-1];

    calc_dabble_step #(.NDIG(NDIG)) u_step (
        .bcd_in    (bcd),
        .carry_in  (mag[WIDTH-1]),
        .bcd_out   (bcd_next),
        .carry_out (bcd_carry)
    );

    // Blank zeros above the leading digit; the units digit always shows.
    always_comb begin
        logic seen;
        seen     = 1'b0;
        composed = {(NDIG+1){DIG_BLANK}};
        for (int i = NDIG - 1; i >= 0; i--) begin
            if (bcd[4*i +: 4] != 4'd0 || i == 0) begin
                seen = 1'b1;
            end
            composed[4*i +: 4] = seen ? bcd[4*i +: 4] : DIG_BLANK;
        end
        composed[4*NDIG +: 4] = neg_r ? DIG_MINUS : DIG_BLANK;
        if (ovf_r) begin
            composed = {(NDIG+1){DIG_H}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            digits <= {(NDIG+1){DIG_BLANK}};
            bcd    <= '0;
            mag    <= '0;
            cnt    <= '0;
            neg_r  <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        neg_r <= neg_in;
                        ovf_r <= ovf;
                        mag   <= neg_in ? (~value + 1'b1) : value;
                        bcd   <= '0;
                        cnt   <= CW'(WIDTH);
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd   <= bcd_next;
                    mag   <= {mag[WIDTH-2:0], 1'b0};
                    cnt   <= cnt - 1'b1;
                    // A carry out of the top digit means the display is too narrow.
                    ovf_r <= ovf_r | bcd_carry;
                    if (cnt == CW'(1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    digits <= composed;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_bin_to_digits.sv
// Directed bench for calc_bin_to_digits: reset state, conversions, overflow,
// ignored start while busy, back-to-back start and mid-conversion reset.
module tb_calc_bin_to_digits;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  value;
    logic        is_signed;
    logic        ovf;
    logic        busy;
    logic        done;
    logic [15:0] digits;

    int checks = 0;
    int errors = 0;

    calc_bin_to_digits #(.WIDTH(8), .NDIG(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .value     (value),
        .is_signed (is_signed),
        .ovf       (ovf),
        .busy      (busy),
        .done      (done),
        .digits    (digits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called #1 after an edge; start is sampled on the next edge.
    // Counts edges from acceptance until done (expected 10).
    task automatic convert(input string tag, input logic [7:0] v, input logic s,
                           input logic o, input logic [15:0] exp);
        int n;
        value     = v;
        is_signed = s;
        ovf       = o;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n     = 1;
        check({tag, "_busy"}, busy, 1'b1);
        value     = ~v;
        is_signed = ~s;
        ovf       = ~o;
        while (!done && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, n, 10);
        check({tag, "_dig"}, digits, exp);
    endtask

    initial begin
        int pulses;
        rst_n     = 1'b0;
        start     = 1'b1;
        value     = 8'd99;
        is_signed = 1'b0;
        ovf       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dig", digits, 16'hDDDD);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", busy, 1'b0);
        check("idle_dig", digits, 16'hDDDD);

        convert("u255", 8'd255, 1'b0, 1'b0, 16'hD255);
        check("u255_hold", digits, 16'hD255);
        repeat (2) @(posedge clk);
        #1;
        check("u255_busy_after", busy, 1'b0);
        check("u255_done_after", done, 1'b0);
        check("u255_still", digits, 16'hD255);

        convert("u0",   8'd0,   1'b0, 1'b0, 16'hDDD0);
        convert("u7",   8'd7,   1'b0, 1'b0, 16'hDDD7);
        convert("s-10", 8'hF6,  1'b1, 1'b0, 16'hBD10);
        convert("s-128",8'h80,  1'b1, 1'b0, 16'hB128);
        convert("s127", 8'h7F,  1'b1, 1'b0, 16'hD127);
        convert("u128", 8'h80,  1'b0, 1'b0, 16'hD128);
        convert("ovf",  8'd12,  1'b0, 1'b1, 16'hAAAA);
        @(posedge clk); #1;

        // Start pulse three cycles into a conversion must be ignored.
        value = 8'd100; is_signed = 1'b0; ovf = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        value = 8'd5; start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("busy_start_pulses", pulses, 1);
        check("busy_start_dig", digits, 16'hD100);

        // Back-to-back: second start issued in the done cycle.
        convert("b2b_a", 8'd33, 1'b0, 1'b0, 16'hDD33);
        convert("b2b_b", 8'd250, 1'b0, 1'b0, 16'hD250);

        // Reset pulse mid-SHIFT aborts with no done pulse.
        value = 8'd200; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_busy", busy, 1'b0);
        check("abort_dig", digits, 16'hDDDD);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("abort_pulses", pulses, 0);
        check("abort_dig_late", digits, 16'hDDDD);
        convert("u42", 8'd42, 1'b0, 1'b0, 16'hDD42);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
